// File: rtl/minbd_eject_stage_if.sv
// Port bundle for the MinBD ejection stage: four network input/output flit
// lanes plus the ejection FIFO handshake and status toward the local PE.
interface minbd_eject_stage_if #(
    parameter int FLIT_W     = 16,
    parameter int FIFO_DEPTH = 4
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [FLIT_W-1:0] in_n;
    logic [FLIT_W-1:0] in_e;
    logic [FLIT_W-1:0] in_s;
    logic [FLIT_W-1:0] in_w;
    logic [FLIT_W-1:0] out_n;
    logic [FLIT_W-1:0] out_e;
    logic [FLIT_W-1:0] out_s;
    logic [FLIT_W-1:0] out_w;
    logic [FLIT_W-1:0] ej_flit;
    logic              ej_valid;
    logic              ej_ready;
    logic [CNT_W-1:0]  ej_count;
    logic [15:0]       defl_local_cnt;

    // Router / PE side: drives incoming flits and the PE ready.
    modport master (
        output in_n, in_e, in_s, in_w, ej_ready,
        input  out_n, out_e, out_s, out_w, ej_flit, ej_valid, ej_count, defl_local_cnt
    );

    // Ejection stage side.
    modport slave (
        input  in_n, in_e, in_s, in_w, ej_ready,
        output out_n, out_e, out_s, out_w, ej_flit, ej_valid, ej_count, defl_local_cnt
    );
endinterface

// File: rtl/minbd_eject_stage.sv
// MinBD ejection stage: each cycle removes up to EJECT_N flits addressed to
// this node (round-robin over N/E/S/W) into a small FIFO drained by the PE,
// and registers all remaining flits (ejected slots zeroed) toward the
// permutation stage. Local flits left behind are counted as deflected.
module minbd_eject_stage #(
    parameter int FLIT_W     = 16,
    parameter int COORD_W    = 3,
    parameter int MY_X       = 1,
    parameter int MY_Y       = 2,
    parameter int EJECT_N    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    minbd_eject_stage_if.slave  bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    // Wide enough for space/limit/push arithmetic without overflow.
    localparam int SUM_W = CNT_W + 3;

    // A flit is local when valid and both destination coordinates match.
    function automatic logic is_local(input logic [FLIT_W-1:0] f);
        return f[FLIT_W-1]
            && (f[2*COORD_W-1:COORD_W] == COORD_W'(MY_X))
            && (f[COORD_W-1:0] == COORD_W'(MY_Y));
    endfunction

    logic [FLIT_W-1:0] in_flit_s   [4];
    logic [FLIT_W-1:0] out_r       [4];
    logic [FLIT_W-1:0] push_flit_s [4];
    logic [FLIT_W-1:0] mem_r       [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic [CNT_W-1:0]  count_next_s;
    logic [1:0]        rr_r;
    logic [1:0]        rr_next_s;
    logic [1:0]        idx_s;
    logic [15:0]       defl_r;
    logic [15:0]       defl_next_s;
    logic [16:0]       defl_sum_s;
    logic [3:0]        eject_s;
    logic [SUM_W-1:0]  space_s;
    logic [SUM_W-1:0]  limit_s;
    logic [SUM_W-1:0]  push_cnt_s;
    logic [2:0]        miss_cnt_s;
    logic              pop_s;

    assign in_flit_s[0] = bus.in_n;
    assign in_flit_s[1] = bus.in_e;
    assign in_flit_s[2] = bus.in_s;
    assign in_flit_s[3] = bus.in_w;

    assign bus.out_n          = out_r[0];
    assign bus.out_e          = out_r[1];
    assign bus.out_s          = out_r[2];
    assign bus.out_w          = out_r[3];
    assign bus.ej_flit        = mem_r[rd_ptr_r];
    assign bus.ej_valid       = (count_r != '0);
    assign bus.ej_count       = count_r;
    assign bus.defl_local_cnt = defl_r;

    // Ejection selection: budget from start-of-cycle occupancy, round-robin scan.
    always_comb begin
        space_s    = SUM_W'(FIFO_DEPTH) - SUM_W'(count_r);
        eject_s    = 4'b0000;
        push_cnt_s = '0;
        miss_cnt_s = 3'd0;
        rr_next_s  = rr_r;
        idx_s      = rr_r;
        for (int k = 0; k < 4; k++) begin
            push_flit_s[k] = '0;
        end
        if (space_s > SUM_W'(EJECT_N)) begin
            limit_s = SUM_W'(EJECT_N);
        end else begin
            limit_s = space_s;
        end
        for (int k = 0; k < 4; k++) begin
            idx_s = rr_r + 2'(k);
            if (is_local(in_flit_s[idx_s])) begin
                if (push_cnt_s < limit_s) begin
                    eject_s[idx_s]                = 1'b1;
                    push_flit_s[push_cnt_s[1:0]]  = in_flit_s[idx_s];
                    push_cnt_s                    = push_cnt_s + SUM_W'(1);
                    rr_next_s                     = idx_s + 2'd1;
                end else begin
                    miss_cnt_s = miss_cnt_s + 3'd1;
                end
            end else begin
                eject_s[idx_s] = 1'b0;
            end
        end
    end

    // FIFO bookkeeping and saturating deflection counter update.
    always_comb begin
        pop_s        = (count_r != '0) && bus.ej_ready;
        count_next_s = count_r + CNT_W'(push_cnt_s) - CNT_W'(pop_s);
        defl_sum_s   = 17'(defl_r) + 17'(miss_cnt_s);
        if (defl_sum_s[16]) begin
            defl_next_s = 16'hFFFF;
        end else begin
            defl_next_s = defl_sum_s[15:0];
        end
    end

    // Pipeline registers, FIFO pointers, round-robin pointer and counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                out_r[k] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            rr_r     <= 2'd0;
            defl_r   <= 16'd0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                out_r[k] <= eject_s[k] ? '0 : in_flit_s[k];
            end
            wr_ptr_r <= wr_ptr_r + PTR_W'(push_cnt_s);
            rd_ptr_r <= rd_ptr_r + PTR_W'(pop_s);
            count_r  <= count_next_s;
            rr_r     <= rr_next_s;
            defl_r   <= defl_next_s;
        end
    end

    // FIFO storage: ejected flits are written in scan order at the write pointer.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (SUM_W'(k) < push_cnt_s) begin
                mem_r[wr_ptr_r + PTR_W'(k)] <= push_flit_s[k];
            end
        end
    end
endmodule

// File: tb/tb_minbd_eject_stage.sv
// Scoreboard bench for minbd_eject_stage: a queue-based reference model
// predicts pass-through outputs, occupancy and deflection count per cycle,
// and the order of flits delivered to the PE.
module tb_minbd_eject_stage;
    localparam int FLIT_W     = 16;
    localparam int COORD_W    = 3;
    localparam int MY_X       = 1;
    localparam int MY_Y       = 2;
    localparam int EJECT_N    = 2;
    localparam int FIFO_DEPTH = 4;

    typedef logic [3:0][FLIT_W-1:0] quad_t;
    typedef struct {
        quad_t o;
        int    cnt;
        int    defl;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    minbd_eject_stage_if #(.FLIT_W(FLIT_W), .FIFO_DEPTH(FIFO_DEPTH)) bus();

    minbd_eject_stage #(
        .FLIT_W(FLIT_W), .COORD_W(COORD_W), .MY_X(MY_X), .MY_Y(MY_Y),
        .EJECT_N(EJECT_N), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int tests = 0;
    int fails = 0;

    exp_t        exp_q[$];
    logic [15:0] exp_ej[$];
    int          m_rr   = 0;
    int          m_occ  = 0;
    int          m_defl = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_local_ref(input logic [15:0] f);
        int x, y;
        x = (int'(f) >> 3) % 8;
        y = int'(f) % 8;
        return f[15] && (x == MY_X) && (y == MY_Y);
    endfunction

    function automatic logic [15:0] lf(input int payload);
        logic [8:0] p;
        p = 9'(payload);
        return {1'b1, p, 6'b001010};
    endfunction

    function automatic quad_t mk(input logic [15:0] n, input logic [15:0] e,
                                 input logic [15:0] s, input logic [15:0] w);
        quad_t q;
        q[0] = n; q[1] = e; q[2] = s; q[3] = w;
        return q;
    endfunction

    // Drive one cycle of stimulus and record the model's prediction for it.
    task automatic cycle(input quad_t f, input bit rdy, input bit do_rst);
        exp_t e;
        int   limit, taken, miss, last, p;
        bit   pop;
        @(posedge clk);
        #2;
        bus.in_n     = f[0];
        bus.in_e     = f[1];
        bus.in_s     = f[2];
        bus.in_w     = f[3];
        bus.ej_ready = rdy;
        rst          = do_rst;
        if (do_rst) begin
            m_rr = 0; m_occ = 0; m_defl = 0;
            exp_ej.delete();
            e.o = '0; e.cnt = 0; e.defl = 0;
        end else begin
            limit = FIFO_DEPTH - m_occ;
            if (limit > EJECT_N) limit = EJECT_N;
            pop   = (m_occ > 0) && rdy;
            taken = 0; miss = 0; last = 0;
            e.o   = f;
            for (int k = 0; k < 4; k++) begin
                p = (m_rr + k) % 4;
                if (is_local_ref(f[p])) begin
                    if (taken < limit) begin
                        exp_ej.push_back(f[p]);
                        e.o[p] = '0;
                        taken++;
                        last = p;
                    end else begin
                        miss++;
                    end
                end
            end
            if (taken > 0) m_rr = (last + 1) % 4;
            m_occ  = m_occ + taken - (pop ? 1 : 0);
            m_defl = (m_defl + miss > 65535) ? 65535 : m_defl + miss;
            e.cnt  = m_occ;
            e.defl = m_defl;
        end
        exp_q.push_back(e);
    endtask

    // Monitor: registered outputs and status just after each active edge.
    initial begin
        exp_t  e;
        quad_t act;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = mk(bus.out_n, bus.out_e, bus.out_s, bus.out_w);
                chk("out_n", 32'(act[0]), 32'(e.o[0]));
                chk("out_e", 32'(act[1]), 32'(e.o[1]));
                chk("out_s", 32'(act[2]), 32'(e.o[2]));
                chk("out_w", 32'(act[3]), 32'(e.o[3]));
                chk("ej_count", 32'(bus.ej_count), 32'(e.cnt));
                chk("ej_valid", 32'(bus.ej_valid), 32'(e.cnt != 0));
                chk("defl_local_cnt", 32'(bus.defl_local_cnt), 32'(e.defl));
                chk("no_overflow", 32'(bus.ej_count <= 3'(FIFO_DEPTH)), 32'd1);
            end
        end
    end

    // Monitor: FIFO head against expected delivery order, popped on handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && bus.ej_valid) begin
                if (exp_ej.size() == 0) begin
                    chk("ej_spurious", 32'(bus.ej_flit), 32'hFFFF_FFFF);
                end else begin
                    chk("ej_flit", 32'(bus.ej_flit), 32'(exp_ej[0]));
                    if (bus.ej_ready) exp_ej.delete(0);
                end
            end
        end
    end

    // Time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog expired");
    end

    // Stimulus: directed scenarios followed by randomized traffic.
    initial begin
        quad_t f;
        int    r;
        bus.in_n = '0; bus.in_e = '0; bus.in_s = '0; bus.in_w = '0;
        bus.ej_ready = 1'b0;

        // Reset then idle.
        cycle('0, 1'b0, 1'b1);
        cycle('0, 1'b0, 1'b1);
        cycle('0, 1'b0, 1'b0);
        cycle('0, 1'b0, 1'b0);

        // Single eject on E.
        cycle(mk(16'h8013, 16'h800A, 16'h8013, 16'h8013), 1'b1, 1'b0);
        cycle(mk(16'h8013, 16'h8013, 16'h8013, 16'h8013), 1'b1, 1'b0);
        cycle('0, 1'b1, 1'b0);

        // Reset mid-run, then priority/budget with all four local.
        cycle('0, 1'b0, 1'b1);
        cycle(mk(lf(1), lf(2), lf(3), lf(4)), 1'b0, 1'b0);
        cycle(mk(lf(1), lf(2), lf(3), lf(4)), 1'b0, 1'b0);

        // FIFO full: local flit must pass and be counted.
        cycle(mk(16'h800A, 16'h0000, 16'h0000, 16'h0000), 1'b0, 1'b0);
        cycle(mk(16'h800A, 16'h800A, 16'h0000, 16'h0000), 1'b1, 1'b0);

        // Backpressure then drain.
        for (int i = 0; i < 5; i++) cycle('0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cycle('0, 1'b1, 1'b0);

        // Wrap with simultaneous push/pop.
        cycle('0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            f = '0;
            f[i % 4] = lf(i + 10);
            cycle(f, 1'b1, 1'b0);
        end

        // Randomized traffic with occasional reset.
        for (int i = 0; i < 400; i++) begin
            for (int p = 0; p < 4; p++) begin
                r = $urandom_range(0, 7);
                if (r < 4)       f[p] = lf($urandom_range(0, 511));
                else if (r < 6)  f[p] = {1'b1, 15'($urandom)};
                else if (r == 6) f[p] = {1'b0, 9'($urandom), 6'b001010};
                else             f[p] = '0;
            end
            cycle(f, 1'($urandom_range(0, 2) != 0), ($urandom_range(0, 49) == 0));
        end

        // Drain and settle.
        for (int i = 0; i < 8; i++) cycle('0, 1'b1, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #3;
        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        chk("ej_drained", 32'(exp_ej.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/minbd_eject_stage.md
# minbd_eject_stage

Parametrised, pipelined ejection stage for the MinBD deflection router. Each cycle it takes one flit from each of the four router inputs (N, E, S, W) and removes up to EJECT_N flits addressed to the local node into an ejection FIFO. Removed flits become bubbles; all other flits pass through a one-cycle register to the permutation stage. The FIFO drains to the local PE over a valid/ready handshake. Local flits that cannot be ejected stay in the network and are deflected.

## Interface
- FLIT_W, 16, flit width; bit FLIT_W-1 = valid, [2*COORD_W-1:COORD_W] = dst_x, [COORD_W-1:0] = dst_y
- COORD_W, 3, coordinate field width
- MY_X, 1, local X coordinate
- MY_Y, 2, local Y coordinate
- EJECT_N, 2, maximum ejections per cycle (1..4)
- FIFO_DEPTH, 4, ejection FIFO entries (power of two, ≥ EJECT_N)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_n, in_e, in_s, in_w  in  FLIT_W  incoming flits
- out_n, out_e, out_s, out_w  out  FLIT_W  registered pass-through flits; ejected slots are all-zero
- ej_flit  out  FLIT_W  FIFO head
- ej_valid  out  1  FIFO non-empty
- ej_ready  in  1  PE accepts head
- ej_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- defl_local_cnt  out  16  saturating count of local flits left in the network

## Operation
- Local match: valid=1, dst_x==MY_X and dst_y==MY_Y.
- Budget per cycle: limit = min(EJECT_N, FIFO_DEPTH − ej_count), using the count at the start of the cycle. A same-cycle pop does not add space.
- Round-robin pointer rr (2 bits): 0=N, 1=E, 2=S, 3=W. Scan ports rr, rr+1, rr+2, rr+3 (mod 4). Eject the first `limit` local matches.
- Ejected flits are written into the FIFO in scan order, so the first scanned is the first read out.
- If at least one flit is ejected, rr ← (index of the last ejected port + 1) mod 4. Otherwise rr holds.
- Each out_x register loads 0 if its port ejected this cycle, else in_x unchanged. Non-local and invalid flits always pass through.
- defl_local_cnt: each cycle it adds the number of local matches not ejected. It saturates at 16'hFFFF.
- FIFO:
  - Circular buffer with write and read pointers that wrap at FIFO_DEPTH.
  - Pop when ej_valid && ej_ready.
  - A push and a pop in the same cycle are both performed.
  - The occupancy update is count + pushes − pop.
  - Overflow cannot occur by construction. The bench asserts this.
- Reset: all out_x = 0, FIFO empty (ej_valid=0, ej_count=0), pointers = 0, rr = 0, defl_local_cnt = 0. ej_flit is don't-care while ej_valid=0. Assertion mid-operation discards any FIFO contents and in-flight flits immediately.

## Timing
- Pass-through latency: 1 cycle, in_x at edge t appears on out_x after edge t.
- Ejection latency: a flit ejected at edge t is visible on ej_flit/ej_valid after edge t, provided the FIFO was empty.
- The handshake is combinational from FIFO state. ej_flit is held stable while ej_valid && !ej_ready.
- Full FIFO: limit = 0. Every local flit passes through and is counted as deflected, even if ej_ready=1 that cycle.
- No combinational path exists from in_x to out_x or ej_*.

## Test plan
Default parameters: local flit 16'h800A; non-local 16'h8013.

- Reset then idle: rst=1 mid-run, all inputs 0 → out_x = 0, ej_valid=0, ej_count=0, defl_local_cnt=0.
- Single eject: in_e=16'h800A, others 16'h8013, ej_ready=1 → next cycle out_e=0, other outputs 16'h8013, ej_flit=16'h800A, ej_valid=1; rr becomes 2.
- Priority/budget: rr=0, all four inputs local (payloads 1, 2, 3, 4 in bits [14:6]), ej_ready=0 → N and E are ejected and appear in that order. out_s and out_w carry their flits. defl_local_cnt=2, rr=2. Repeating the same cycle ejects S and W.
- Full FIFO: ej_ready=0, fill to ej_count=4, then in_n=16'h800A → out_n=16'h800A passes through, ej_count stays 4, defl_local_cnt increments by 1.
- Backpressure: ej_valid=1, ej_ready held 0 for 5 cycles → ej_flit stable. ej_ready=1 → one pop per cycle, in FIFO order.
- Wrap and simultaneous push/pop: 10 consecutive cycles with one local flit each and ej_ready=1 → ej_count stays 1 and flits are delivered in order across pointer wrap. defl_local_cnt=0.
